fdce_bank_arbiter: RTL and testbench

- Round-robin write arbiter for a shared W-bit register bank built from FDCE cells (clock C, enable CE, data D).
- N requesters compete for the bank. The block serializes their writes by driving the bank's CE and D, and returns a one-cycle acknowledge to each winner.
- It sits between requester logic and the fdce_wrapper-based bank, which is the only writer path to the bank.

---
 rtl/fdce_bank_arbiter.sv | 136 +++++++++++++
 tb/tb_fdce_bank_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdce_bank_arbiter.sv
// Round-robin write arbiter for a shared FDCE register bank: serializes requester writes
// onto the bank's CE/D pins and returns a one-cycle acknowledge to each winner.
module fdce_bank_arbiter #(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             C,
    input  logic             CLR,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   wdata,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic             bank_ce,
    output logic [W-1:0]     bank_d,
    output logic             busy
);

    localparam int              PW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0]   LAST_IDX  = PW'(N - 1);
    localparam logic [3:0]      HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
    localparam logic [N-1:0]    ONE_N     = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            bank_ce_q, bank_ce_d;
    logic [W-1:0]    bank_d_q, bank_d_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   winner_s;

    // Scan downward so the lowest offset from the pointer is written last and wins.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] pick;
        int            idx;
        pick = p;
        for (int k = N - 1; k >= 0; k--) begin
            idx  = int'(p) + k;
            idx  = (idx >= N) ? (idx - N) : idx;
            pick = r[idx[PW-1:0]] ? idx[PW-1:0] : pick;
        end
        return pick;
    endfunction

    // Round-robin winner selection from the current pointer.
    always_comb begin
        winner_s = rr_pick(req, ptr_q);
    end

    // Next-state and next-output computation for the IDLE/WRITE/HOLD sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        ack_d     = '0;
        bank_ce_d = 1'b0;
        bank_d_d  = bank_d_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d   = ST_WRITE;
                    win_d     = winner_s;
                    gnt_d     = ONE_N << winner_s;
                    bank_ce_d = 1'b1;
                    bank_d_d  = wdata[winner_s*W +: W];
                    ptr_d     = (winner_s == LAST_IDX) ? '0 : (winner_s + PW'(1));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                ack_d = ONE_N << win_q;
                if (HOLD_CYCLES > 0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; CLR wins over everything, including a WRITE in flight.
    always_ff @(posedge C) begin
        if (CLR) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= 4'd0;
            gnt_q     <= '0;
            ack_q     <= '0;
            bank_ce_q <= 1'b0;
            bank_d_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            bank_ce_q <= bank_ce_d;
            bank_d_q  <= bank_d_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign bank_ce = bank_ce_q;
    assign bank_d  = bank_d_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fdce_bank_arbiter.sv
// Scoreboard bench for fdce_bank_arbiter: instance A uses HOLD_CYCLES=2, instance B uses
// HOLD_CYCLES=0; each has a behavioural FDCE bank register fed by bank_ce/bank_d.
module tb_fdce_bank_arbiter;

    logic        C = 1'b0;
    logic        CLR;
    logic [3:0]  req_a, gnt_a, ack_a, req_b, gnt_b, ack_b;
    logic [31:0] wdata_a, wdata_b;
    logic        ce_a, ce_b, busy_a, busy_b;
    logic [7:0]  d_a, d_b, bank_q_a, bank_q_b;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 C = ~C;

    fdce_bank_arbiter #(.N(4), .W(8), .HOLD_CYCLES(2)) dut_a (
        .C(C), .CLR(CLR), .req(req_a), .wdata(wdata_a), .gnt(gnt_a), .ack(ack_a),
        .bank_ce(ce_a), .bank_d(d_a), .busy(busy_a)
    );

    fdce_bank_arbiter #(.N(4), .W(8), .HOLD_CYCLES(0)) dut_b (
        .C(C), .CLR(CLR), .req(req_b), .wdata(wdata_b), .gnt(gnt_b), .ack(ack_b),
        .bank_ce(ce_b), .bank_d(d_b), .busy(busy_b)
    );

    // Behavioural FDCE banks and a cycle counter.
    always @(posedge C) begin
        cyc <= cyc + 1;
        if (ce_a) bank_q_a <= d_a;
        if (ce_b) bank_q_b <= d_b;
    end

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        logic [3:0] eg;
        CLR = 1'b1;
        req_a = 4'b1111;
        for (int i = 0; i < 4; i++) wdata_a[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({gnt_a, ack_a, ce_a, busy_a} !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: got gnt=%b ack=%b ce=%b busy=%b, want all 0",
                         i, gnt_a, ack_a, ce_a, busy_a);
            end
        end
        sb_a.push_back('{0, 8'h10});
        CLR = 1'b0;
        tick();
        e = sb_a.pop_front();
        eg = 4'b0001 << e.idx;
        checks++;
        if (gnt_a !== eg || d_a !== e.data || ce_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got gnt=%b d=%h ce=%b, want gnt=%b d=%h ce=1",
                     gnt_a, d_a, ce_a, eg, e.data);
        end
        req_a = 4'b0000;
        for (int k = 0; k < 20 && busy_a !== 1'b0; k++) tick();
    endtask

    task automatic test_single;
        exp_t e;
        logic [3:0] eg;
        req_a = 4'b0100;
        wdata_a[23:16] = 8'hA5;
        sb_a.push_back('{2, 8'hA5});
        tick();
        e = sb_a.pop_front();
        eg = 4'b0001 << e.idx;
        checks++;
        if (gnt_a !== eg || ce_a !== 1'b1 || d_a !== e.data || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL single_write: got gnt=%b ce=%b d=%h busy=%b, want gnt=%b ce=1 d=%h busy=1",
                     gnt_a, ce_a, d_a, busy_a, eg, e.data);
        end
        wdata_a[23:16] = 8'h00;
        req_a = 4'b0000;
        tick();
        checks++;
        if (ack_a !== eg || gnt_a !== 4'b0000 || ce_a !== 1'b0 || bank_q_a !== e.data || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: got ack=%b gnt=%b ce=%b Q=%h busy=%b, want ack=%b gnt=0 ce=0 Q=%h busy=1",
                     ack_a, gnt_a, ce_a, bank_q_a, busy_a, eg, e.data);
        end
        tick();
        checks++;
        if (busy_a !== 1'b1 || ack_a !== 4'b0000) begin
            errors++;
            $display("FAIL single_hold: got busy=%b ack=%b, want busy=1 ack=0000", busy_a, ack_a);
        end
        tick();
        checks++;
        if (busy_a !== 1'b0 || d_a !== 8'hA5 || ce_a !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b d=%h ce=%b, want busy=0 d=a5 ce=0", busy_a, d_a, ce_a);
        end
    endtask

    task automatic test_fairness;
        exp_t e;
        logic [3:0] eg;
        int prev;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        req_a = 4'b1111;
        for (int i = 0; i < 4; i++) wdata_a[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 5; i++) sb_a.push_back('{i % 4, 8'h10 + 8'(i % 4)});
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < 12 && ce_a !== 1'b1; k++) tick();
            e = sb_a.pop_front();
            eg = 4'b0001 << e.idx;
            checks++;
            if (gnt_a !== eg || d_a !== e.data || ce_a !== 1'b1) begin
                errors++;
                $display("FAIL fair_grant n=%0d: got gnt=%b d=%h ce=%b, want gnt=%b d=%h ce=1",
                         n, gnt_a, d_a, ce_a, eg, e.data);
            end
            if (n > 0) begin
                checks++;
                if (cyc - prev != 4) begin
                    errors++;
                    $display("FAIL fair_spacing n=%0d: got %0d cycles, want 4", n, cyc - prev);
                end
            end
            prev = cyc;
            if (n == 4) req_a = 4'b0000;
            tick();
            checks++;
            if (ack_a !== eg || bank_q_a !== e.data) begin
                errors++;
                $display("FAIL fair_ack n=%0d: got ack=%b Q=%h, want ack=%b Q=%h", n, ack_a, bank_q_a, eg, e.data);
            end
        end
        for (int k = 0; k < 20 && busy_a !== 1'b0; k++) tick();
    endtask

    task automatic test_wrap;
        exp_t e;
        logic [3:0] eg;
        req_a = 4'b0010;
        for (int i = 0; i < 4; i++) wdata_a[i*8 +: 8] = 8'h30 + 8'(i);
        sb_a.push_back('{1, 8'h31});
        sb_a.push_back('{3, 8'h33});
        sb_a.push_back('{0, 8'h30});
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 12 && ce_a !== 1'b1; k++) tick();
            e = sb_a.pop_front();
            eg = 4'b0001 << e.idx;
            checks++;
            if (gnt_a !== eg || d_a !== e.data) begin
                errors++;
                $display("FAIL wrap_grant n=%0d: got gnt=%b d=%h, want gnt=%b d=%h", n, gnt_a, d_a, eg, e.data);
            end
            if (n == 0) req_a = 4'b1001;
            if (n == 2) req_a = 4'b0000;
            tick();
            checks++;
            if (ack_a !== eg) begin
                errors++;
                $display("FAIL wrap_ack n=%0d: got ack=%b, want %b", n, ack_a, eg);
            end
        end
        for (int k = 0; k < 20 && busy_a !== 1'b0; k++) tick();
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [3:0] eg;
        int prev;
        req_b = 4'b0011;
        for (int i = 0; i < 4; i++) wdata_b[i*8 +: 8] = 8'h20 + 8'(i);
        for (int i = 0; i < 4; i++) sb_b.push_back('{i % 2, 8'h20 + 8'(i % 2)});
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 8 && ce_b !== 1'b1; k++) tick();
            e = sb_b.pop_front();
            eg = 4'b0001 << e.idx;
            checks++;
            if (gnt_b !== eg || d_b !== e.data || ce_b !== 1'b1) begin
                errors++;
                $display("FAIL b2b_grant n=%0d: got gnt=%b d=%h ce=%b, want gnt=%b d=%h ce=1",
                         n, gnt_b, d_b, ce_b, eg, e.data);
            end
            if (n > 0) begin
                checks++;
                if (cyc - prev != 2) begin
                    errors++;
                    $display("FAIL b2b_spacing n=%0d: got %0d cycles, want 2", n, cyc - prev);
                end
            end
            prev = cyc;
            if (n == 3) req_b = 4'b0000;
            tick();
            checks++;
            if (ack_b !== eg || ce_b !== 1'b0 || bank_q_b !== e.data || busy_b !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ack n=%0d: got ack=%b ce=%b Q=%h busy=%b, want ack=%b ce=0 Q=%h busy=0",
                         n, ack_b, ce_b, bank_q_b, busy_b, eg, e.data);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        logic [3:0] eg;
        req_a = 4'b1000;
        wdata_a[31:24] = 8'h77;
        wdata_a[7:0] = 8'h44;
        sb_a.push_back('{3, 8'h77});
        for (int k = 0; k < 12 && ce_a !== 1'b1; k++) tick();
        e = sb_a.pop_front();
        eg = 4'b0001 << e.idx;
        checks++;
        if (gnt_a !== eg || d_a !== e.data) begin
            errors++;
            $display("FAIL mid_grant: got gnt=%b d=%h, want gnt=%b d=%h", gnt_a, d_a, eg, e.data);
        end
        CLR = 1'b1;
        req_a = 4'b1001;
        tick();
        checks++;
        if (ce_a !== 1'b0 || ack_a !== 4'b0000 || gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got ce=%b ack=%b gnt=%b busy=%b, want all 0", ce_a, ack_a, gnt_a, busy_a);
        end
        CLR = 1'b0;
        sb_a.push_back('{0, 8'h44});
        tick();
        e = sb_a.pop_front();
        eg = 4'b0001 << e.idx;
        checks++;
        if (gnt_a !== eg || d_a !== e.data) begin
            errors++;
            $display("FAIL mid_regrant: got gnt=%b d=%h, want gnt=%b d=%h", gnt_a, d_a, eg, e.data);
        end
        req_a = 4'b0000;
        tick();
        checks++;
        if (ack_a !== eg) begin
            errors++;
            $display("FAIL mid_ack: got ack=%b, want %b", ack_a, eg);
        end
    endtask

    initial begin
        CLR = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        wdata_a = 32'h0;
        wdata_b = 32'h0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
